fetch_stage: RTL

- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Holds the PC and drives a ready/valid instruction-memory port.
- Owns the IF/ID pipeline register that feeds the decode stage (opcode/funct to the controller, PC+4 to branch-target logic).
- Takes PC redirects from decode: the beq-taken select plus the computed branch target, and the jump select plus the jump target.

---
 rtl/fetch_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: PC, ready/valid imem port, skid buffer and IF/ID register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_i,
   input  logic        pc_beq_i,
   input  logic [31:0] pc_branch_i32,
   input  logic        pc_j_i,
   input  logic [31:0] pc_jump_i32,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o32,
   input  logic        imem_ready_i,
   input  logic [31:0] imem_rdata_i32,
   output logic [31:0] instr_o32,
   output logic [31:0] pc_plus4_o32,
   output logic        valid_o
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_tgt;
   logic [31:0] r_skid_instr;
   logic [31:0] r_skid_pc4;
   logic [31:0] r_instr;
   logic [31:0] r_pc4;
   logic        r_valid;

   logic        w_redir;
   logic        w_xfer;
   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;

   assign w_redir    = (pc_beq_i | pc_j_i) & ~stall_i;
   assign w_target   = (pc_beq_i ? pc_branch_i32 : pc_jump_i32) & 32'hFFFF_FFFC;
   assign w_pc_plus4 = r_pc + 32'd4;

   // Request is gated by reset so a ready seen during reset can never form a transfer.
   assign imem_req_o    = ~reset_i & (r_state != HOLD);
   assign imem_addr_o32 = r_pc;
   assign w_xfer        = imem_req_o & imem_ready_i;

   assign instr_o32    = r_instr;
   assign pc_plus4_o32 = r_pc4;
   assign valid_o      = r_valid;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state      <= FETCH;
         r_pc         <= RESET_PC;
         r_tgt        <= 32'd0;
         r_skid_instr <= 32'd0;
         r_skid_pc4   <= 32'd0;
         r_instr      <= 32'd0;
         r_pc4        <= 32'd0;
         r_valid      <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               if (w_redir) begin
                  r_valid <= 1'b0;
                  if (w_xfer) begin
                     r_pc <= w_target;
                  end else begin
                     r_tgt   <= w_target;
                     r_state <= DRAIN;
                  end
               end else if (w_xfer) begin
                  r_pc <= w_pc_plus4;
                  if (stall_i) begin
                     r_skid_instr <= imem_rdata_i32;
                     r_skid_pc4   <= w_pc_plus4;
                     r_state      <= HOLD;
                  end else begin
                     r_instr <= imem_rdata_i32;
                     r_pc4   <= w_pc_plus4;
                     r_valid <= 1'b1;
                  end
               end else if (!stall_i) begin
                  r_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  r_state <= FETCH;
                  if (w_redir) begin
                     r_pc    <= w_target;
                     r_valid <= 1'b0;
                  end else begin
                     r_instr <= r_skid_instr;
                     r_pc4   <= r_skid_pc4;
                     r_valid <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               // The stale request must complete before the new target can be issued.
               if (!stall_i) begin
                  r_valid <= 1'b0;
               end
               if (w_redir) begin
                  r_tgt <= w_target;
               end
               if (w_xfer) begin
                  r_pc    <= w_redir ? w_target : r_tgt;
                  r_state <= FETCH;
               end
            end
            default: begin
               r_state <= FETCH;
            end
         endcase
      end
   end

endmodule
